// File: rtl/ifetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_queue
//
// Purpose:
//   Instruction fetch stage that sits directly behind the simulation
//   instruction memory. It owns the fetch PC and drives a word address to the
//   memory every cycle. The memory answers one cycle later with a word in its
//   own byte order. This block byte-reverses that word into RISC-V order and
//   buffers up to two {pc, inst} pairs. Decode drains the buffer through a
//   valid/ready handshake. A redirect from execute flushes every queued fetch
//   and the fetch that is in flight, then starts fetching from the target at
//   once.
//
// Parameters:
//   RESET_PC        PC of the first fetch after reset (word aligned).
//
// Ports:
//   clk             clock, all state updates on the rising edge
//   rst             synchronous active-high reset
//   imem_addr       word address to instruction memory (PC[31:2])
//   imem_inst       memory word for the previous cycle's address, byte-reversed
//   redirect_valid  replace the fetch PC and flush this cycle
//   redirect_pc     redirect target, bits [1:0] ignored
//   if_valid        queue head holds a valid instruction
//   if_ready        decode accepts the head this cycle
//   if_pc           PC of the head instruction
//   if_inst         head instruction in RISC-V byte order
// ----------------------------------------------------------------------------
module ifetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [29:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    // Fetch state
    logic [31:0] fetch_pc_q,    fetch_pc_d;
    logic        inflight_q,    inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;

    // Two-entry queue. Slot 0 is always the head, and slot 1 is behind it.
    logic [31:0] slot0_pc_q,   slot0_pc_d;
    logic [31:0] slot0_inst_q, slot0_inst_d;
    logic [31:0] slot1_pc_q,   slot1_pc_d;
    logic [31:0] slot1_inst_q, slot1_inst_d;
    logic [1:0]  count_q,      count_d;

    logic [31:0] redirect_target;
    logic [31:0] swapped_inst;
    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occupancy_next;

    // The low bits of the target are forced to zero, so the target is always word aligned.
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    // Convert the memory's byte order to RISC-V order.
    assign swapped_inst = {imem_inst[7:0], imem_inst[15:8],
                           imem_inst[23:16], imem_inst[31:24]};

    // Any handshake in a redirect cycle is discarded together with the
    // entry it would have accepted. Likewise, the response that arrives
    // during a redirect belongs to the old path and is not captured.
    assign pop  = if_valid & if_ready & ~redirect_valid;
    assign push = inflight_q & ~redirect_valid;

    // Issue a new fetch only if its response is sure to find a free slot
    // next cycle. Because of this rule, the queue never overflows, and at
    // most one fetch is ever outstanding.
    assign occupancy_next = {1'b0, count_q} - {2'b00, pop} + {2'b00, push} + 3'd1;
    assign issue          = (occupancy_next <= 3'd2);

    // While reset is held, the address shows the reset PC. This keeps the
    // memory pointed at the restart address even when reset is asserted
    // mid-stream, before the fetch PC register has been reloaded.
    assign imem_addr = rst            ? RESET_PC[31:2]        :
                       redirect_valid ? redirect_target[31:2] :
                                        fetch_pc_q[31:2];

    // The head outputs come straight from registers. This gives no
    // combinational path from if_ready to them.
    assign if_valid = (count_q != 2'd0);
    assign if_pc    = slot0_pc_q;
    assign if_inst  = slot0_inst_q;

    // Next-state logic for fetch control and the queue.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        slot0_pc_d    = slot0_pc_q;
        slot0_inst_d  = slot0_inst_q;
        slot1_pc_d    = slot1_pc_q;
        slot1_inst_d  = slot1_inst_q;
        count_d       = count_q;

        if (redirect_valid) begin
            // Flush, then issue the target in the same cycle. This makes
            // the target reach the head two cycles later.
            count_d       = 2'd0;
            inflight_d    = 1'b1;
            inflight_pc_d = redirect_target;
            fetch_pc_d    = redirect_target + 32'd4;
        end else begin
            inflight_d = issue;
            if (issue) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end

            case ({pop, push})
                2'b10: begin
                    slot0_pc_d   = slot1_pc_q;
                    slot0_inst_d = slot1_inst_q;
                    count_d      = count_q - 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd0) begin
                        slot0_pc_d   = inflight_pc_q;
                        slot0_inst_d = swapped_inst;
                    end else begin
                        slot1_pc_d   = inflight_pc_q;
                        slot1_inst_d = swapped_inst;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    // The occupancy does not change. The new word lands right
                    // behind whatever moves up to the head.
                    if (count_q == 2'd1) begin
                        slot0_pc_d   = inflight_pc_q;
                        slot0_inst_d = swapped_inst;
                    end else begin
                        slot0_pc_d   = slot1_pc_q;
                        slot0_inst_d = slot1_inst_q;
                        slot1_pc_d   = inflight_pc_q;
                        slot1_inst_d = swapped_inst;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers. Reset takes priority over redirect and handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            slot0_pc_q    <= 32'h0;
            slot0_inst_q  <= 32'h0;
            slot1_pc_q    <= 32'h0;
            slot1_inst_q  <= 32'h0;
            count_q       <= 2'd0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            slot0_pc_q    <= slot0_pc_d;
            slot0_inst_q  <= slot0_inst_d;
            slot1_pc_q    <= slot1_pc_d;
            slot1_inst_q  <= slot1_inst_d;
            count_q       <= count_d;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// ----------------------------------------------------------------------------
// tb_ifetch_queue
//
// Purpose:
//   Directed testbench for ifetch_queue. It contains a one-cycle-latency
//   instruction memory model. The memory stores words in reversed byte
//   order, the same way the real simulation memory does.
//
// Scenarios covered:
//   - reset state
//   - sequential fetch while decode is always ready
//   - back-pressure and release
//   - redirect with a full queue and an unaligned target
//   - reset together with a redirect in the same cycle
//   - PC wrap at the top of the address space
// ----------------------------------------------------------------------------
module tb_ifetch_queue;

    logic        clk;
    logic        rst;
    logic [29:0] imemAddr;
    logic [31:0] imemInst;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        ifValid;
    logic        ifReady;
    logic [31:0] ifPc;
    logic [31:0] ifInst;

    int testsRun;
    int testsFailed;

    ifetch_queue #(.RESET_PC(32'h00000000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imemAddr),
        .imem_inst      (imemInst),
        .redirect_valid (redirectValid),
        .redirect_pc    (redirectPc),
        .if_valid       (ifValid),
        .if_ready       (ifReady),
        .if_pc          (ifPc),
        .if_inst        (ifInst)
    );

    // Free-running clock with a 10-time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Program image in RISC-V order. Words not listed here get a simple
    // address-dependent pattern, so that each word is distinguishable.
    function automatic logic [31:0] memWord(input logic [29:0] wordAddr);
        case (wordAddr)
            30'h00:  memWord = 32'h00700393;
            30'h01:  memWord = 32'h00100093;
            30'h02:  memWord = 32'h00200113;
            30'h03:  memWord = 32'h00300193;
            30'h11:  memWord = 32'h008000ef;
            default: memWord = {wordAddr[19:0], 12'h013};
        endcase
    endfunction

    // The memory registers the address on every edge and returns the word
    // byte-reversed one cycle later.
    always @(posedge clk) begin
        imemInst <= {memWord(imemAddr)[7:0], memWord(imemAddr)[15:8],
                     memWord(imemAddr)[23:16], memWord(imemAddr)[31:24]};
    end

    // Watchdog, so that the run always ends even if something goes wrong.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, limit 100000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Sets the inputs for one cycle. Inputs are driven on the falling edge,
    // and the caller samples the outputs 1 time unit later.
    task automatic applyStimulus(input logic rstV, input logic redirV,
                                 input logic [31:0] redirPcV, input logic readyV);
        @(negedge clk);
        rst           = rstV;
        redirectValid = redirV;
        redirectPc    = redirPcV;
        ifReady       = readyV;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Checks one head entry that should be valid: the valid flag, the PC,
    // and the instruction.
    task automatic checkHead(input string tag, input logic [31:0] pc,
                             input logic [31:0] inst);
        checkOutput({tag, ".valid"}, {31'b0, ifValid}, 32'd1);
        checkOutput({tag, ".pc"},    ifPc,             pc);
        checkOutput({tag, ".inst"},  ifInst,           inst);
    endtask

    initial begin
        testsRun      = 0;
        testsFailed   = 0;
        rst           = 1'b1;
        redirectValid = 1'b0;
        redirectPc    = 32'h0;
        ifReady       = 1'b0;

        // Reset state, checked after the first reset edge has taken effect.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("reset.valid", {31'b0, ifValid}, 32'd0);
        checkOutput("reset.pc",    ifPc,             32'h0);
        checkOutput("reset.inst",  ifInst,           32'h0);
        checkOutput("reset.addr",  {2'b0, imemAddr}, 32'h0);

        // Streaming with decode always ready. The first valid arrives in cycle 2.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);                     // cycle 0
        checkOutput("seq.c0.valid", {31'b0, ifValid}, 32'd0);
        checkOutput("seq.c0.addr",  {2'b0, imemAddr}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);                     // cycle 1
        checkOutput("seq.c1.valid", {31'b0, ifValid}, 32'd0);
        checkOutput("seq.c1.addr",  {2'b0, imemAddr}, 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);                     // cycle 2
        checkHead("seq.c2", 32'h0, 32'h00700393);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);                     // cycle 3
        checkHead("seq.c3", 32'h4, 32'h00100093);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);                     // cycle 4
        checkHead("seq.c4", 32'h8, 32'h00200113);

        // Back-pressure. Restart from reset with decode stalled.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);                     // cycle 0
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);                     // cycle 1
        for (int c = 2; c <= 6; c++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);                 // cycles 2..6
        end
        // The queue holds PCs 0 and 4, and issue stalls with the fetch PC at 8.
        checkHead("bp.stall", 32'h0, 32'h00700393);
        checkOutput("bp.stall.addr", {2'b0, imemAddr}, 32'h2);

        // Release: PCs 0, 4, 8, C follow back to back.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);                     // cycle 7
        checkHead("bp.r0", 32'h0, 32'h00700393);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);                     // cycle 8
        checkHead("bp.r1", 32'h4, 32'h00100093);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);                     // cycle 9
        checkHead("bp.r2", 32'h8, 32'h00200113);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);                     // cycle 10
        checkHead("bp.r3", 32'hC, 32'h00300193);

        // Fill the queue with PCs 0x10 and 0x14, then redirect to the
        // unaligned target 0x47, which is treated as 0x44.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);                     // cycle 11
        applyStimulus(1'b0, 1'b1, 32'h00000047, 1'b1);              // cycle 12
        checkHead("redir.full", 32'h10, memWord(30'h4));
        checkOutput("redir.addr", {2'b0, imemAddr}, 32'h11);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);                     // cycle 13
        checkOutput("redir.flush.valid", {31'b0, ifValid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);                     // cycle 14
        checkHead("redir.t2", 32'h44, 32'h008000ef);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);                     // cycle 15
        checkHead("redir.t3", 32'h48, memWord(30'h12));
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);                     // cycle 16
        checkHead("redir.t4", 32'h4C, memWord(30'h13));

        // Reset and redirect in the same cycle: reset wins.
        applyStimulus(1'b1, 1'b1, 32'h00000100, 1'b1);              // cycle 17
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rstredir.valid", {31'b0, ifValid}, 32'd0);
        checkOutput("rstredir.addr",  {2'b0, imemAddr}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rstredir.c1.valid", {31'b0, ifValid}, 32'd0);
        checkOutput("rstredir.c1.addr",  {2'b0, imemAddr}, 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkHead("rstredir.c2", 32'h0, 32'h00700393);

        // Wrap at the top of the address space.
        applyStimulus(1'b0, 1'b1, 32'hFFFFFFFC, 1'b1);
        checkOutput("wrap.addr", {2'b0, imemAddr}, 32'h3FFFFFFF);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap.flush.valid", {31'b0, ifValid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkHead("wrap.top", 32'hFFFFFFFC, 32'hFFFFF013);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkHead("wrap.zero", 32'h00000000, 32'h00700393);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch stage directly downstream of the simulation instruction memory. It owns the fetch PC and drives the memory's word address every cycle. It captures the returned word one cycle later, converts it from the memory's byte order to RISC-V order, and buffers up to two {pc, inst} pairs behind a valid/ready handshake to decode. Redirects from execute (branches, jumps) flush all queued and in-flight fetches.

## Interface
- RESET_PC, 32'h00000000, PC of the first fetch after reset; must be word aligned; 0 matches the memory's reset address.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_addr  out  30  word address to instruction memory (PC[31:2]); memory registers it every edge.
- imem_inst  in  32  memory word for the address presented on the previous cycle, byte-reversed relative to RISC-V order.
- redirect_valid  in  1  replace fetch PC this cycle; flush.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0).
- if_valid  out  1  head of queue holds a valid instruction.
- if_ready  in  1  decode accepts head this cycle.
- if_pc  out  32  PC of head instruction.
- if_inst  out  32  head instruction, RISC-V order.

## Operation
- State: fetch_pc[31:0], inflight (1b), inflight_pc[31:0], 2-entry FIFO of {pc, inst}, count (0..2).
- Byte order: if_inst = {w[7:0], w[15:8], w[23:16], w[31:24]} of the captured imem_inst.
- pop = if_valid & if_ready & !redirect_valid. A handshake in a redirect cycle does not count; that entry is flushed.
- push = inflight & !redirect_valid. On push, the FIFO enqueues {inflight_pc, swapped imem_inst}.
- Issue rule (no redirect): issue = (count - pop + push + 1) <= 2. On issue: inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 4.
- No-issue cycle: inflight <= 0. imem_addr still shows fetch_pc[31:2]; the memory returns a word that is not captured.
- imem_addr = redirect_valid ? redirect_pc[31:2] : fetch_pc[31:2].
- Redirect cycle:
  - count <= 0.
  - The response arriving this cycle is discarded.
  - redirect_pc is issued immediately: inflight <= 1, inflight_pc <= {redirect_pc[31:2], 2'b00}, fetch_pc <= that + 4.
- Only one fetch is ever in flight, because memory latency is exactly one cycle.
- PC arithmetic is 32-bit modulo: 32'hFFFFFFFC + 4 wraps to 32'h00000000.
- Simultaneous pop and push with count==2: legal. The issue rule guarantees push never occurs with count==2 unless pop.
- if_pc/if_inst are don't-care when if_valid==0, but are driven from FIFO storage, which resets to 0.

## Timing
- Reset state: fetch_pc=RESET_PC, inflight=0, count=0, FIFO storage=0.
- Outputs during and after reset: if_valid=0, if_pc=0, if_inst=0, imem_addr=RESET_PC[31:2].
- A rst asserted mid-operation overrides redirect and handshake in that cycle.
- First fetch is issued in the first cycle with rst=0 (cycle 0). Response arrives in cycle 1; if_valid=1 from cycle 2.
- Fetch-to-valid latency: 2 cycles. Redirect-to-valid latency: redirect in cycle t gives if_valid with if_pc=target in cycle t+2.
- Throughput: with if_ready held high, one instruction per cycle, steady-state count=1.
- Backpressure: with if_ready=0, count reaches 2 and issue stops. After if_ready rises, no instruction is dropped or duplicated, and PC order is strictly sequential.
- if_valid, if_pc and if_inst are registered (FIFO head); no combinational path from if_ready to them.

## Test plan
- Reset, then if_ready=1 against the memory image -> if_valid from cycle 2. Sequence (pc,inst): (0,32'h00700393), (4,32'h00100093), (8,32'h00200113), one per cycle.
- Hold if_ready=0 for 5 cycles after first valid, then release -> count saturates at 2 with issue stalled. On release, PCs 0,4,8,C are delivered back to back with no gaps or repeats.
- redirect_valid=1, redirect_pc=32'h00000044 while the queue holds 2 entries -> flush. Two cycles later if_pc=32'h44, if_inst=32'h008000ef, followed by pc 32'h48.
- redirect_pc=32'h00000047 -> treated as 32'h44; imem_addr=30'h11 in the redirect cycle.
- Assert rst for 1 cycle mid-stream with a redirect in the same cycle -> the redirect is ignored, if_valid=0 the next cycle, and fetch restarts at RESET_PC.
- Redirect to 32'hFFFFFFFC with if_ready=1 -> the two delivered PCs are 32'hFFFFFFFC then 32'h00000000.
